led_pattern_gen: RTL

Parametrised LED pattern generator for the Go Board LED bank, driven by the 25 MHz board clock. An internal prescaler produces a step tick. The block drives N_LEDS outputs in one of four run-time-selectable modes: blink, binary count, bouncing scanner and PWM "breathing". It sits directly at the top level between the clock pin and the LED pins.

---
 rtl/led_pkg.sv | 25 ++
 rtl/tick_prescaler.sv | 39 +++
 rtl/led_pattern_gen.sv | 136 +++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared mode encoding and divider helpers for the LED pattern generator
//
// Purpose: pattern mode encoding plus the helpers that derive the prescaler
// division ratio and counter width from the clock and step rates.

package led_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK   = 2'd0,
    MODE_COUNT   = 2'd1,
    MODE_SCAN    = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  // Clock cycles per pattern step.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Prescaler counter width; never narrower than one bit.
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running divider producing a one-cycle step pulse
//
// Purpose: counts 0..DIV-1 and raises TICK for the single cycle in which the
// count sits at DIV-1, giving a pulse every DIV cycles.
// Ports:
//   CLK  - clock
//   RST  - synchronous reset, active-high
//   TICK - registered one-cycle pulse per DIV cycles

module tick_prescaler #(
  parameter int DIV = 8
) (
  input  logic CLK,
  input  logic RST,
  output logic TICK
);
  import led_pkg::*;

  localparam int            CW       = cnt_width(DIV);
  localparam logic [CW-1:0] LAST     = CW'(DIV - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(DIV - 2);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // The pulse is registered one count early so it lines up with LAST.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
      r_tick <= (r_cnt == PRE_LAST);
    end
  end

  assign TICK = r_tick;

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - four-mode LED pattern generator (blink, count, scan, breathe)
//
// Purpose: steps a pattern once per prescaler tick and drives a registered
// LED bank in one of four modes selected at run time.
// Ports:
//   CLK  - board clock
//   RST  - synchronous reset, active-high
//   MODE - pattern select (0 blink, 1 count, 2 scanner, 3 breathe)
//   LED  - LED drive, 1 = on
//   TICK - one-cycle pulse per pattern step

module led_pattern_gen #(
  parameter int CLK_HZ   = 25000000,
  parameter int TICK_HZ  = 8,
  parameter int N_LEDS   = 4,
  parameter int PWM_BITS = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        MODE,
  output logic [N_LEDS-1:0] LED,
  output logic              TICK
);
  import led_pkg::*;

  localparam int                  DIV      = calc_div(CLK_HZ, TICK_HZ);
  localparam int                  PW       = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam logic [PW-1:0]       POS_MAX  = PW'(N_LEDS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  logic                w_tick;
  mode_e               w_mode_in;
  logic [N_LEDS-1:0]   w_scan;
  logic [N_LEDS-1:0]   w_led;

  mode_e               r_mode;
  logic [N_LEDS-1:0]   r_step;
  logic [PW-1:0]       r_pos;
  logic                r_pos_down;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_duty_down;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [N_LEDS-1:0]   r_led;

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .CLK  (CLK),
    .RST  (RST),
    .TICK (w_tick)
  );

  assign w_mode_in = mode_e'(MODE);
  assign w_scan    = N_LEDS'(1) << r_pos;

  // Output select works only from registered state, so MODE never reaches LED
  // combinationally.
  always_comb begin
    w_led = '0;
    case (r_mode)
      MODE_BLINK:   w_led = {N_LEDS{r_step[0]}};
      MODE_COUNT:   w_led = r_step;
      MODE_SCAN:    w_led = w_scan;
      MODE_BREATHE: w_led = {N_LEDS{r_pwm_cnt < r_duty}};
      default:      w_led = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mode      <= MODE_BLINK;
      r_step      <= '0;
      r_pos       <= '0;
      r_pos_down  <= 1'b0;
      r_duty      <= '0;
      r_duty_down <= 1'b0;
      r_pwm_cnt   <= '0;
      r_led       <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      r_led     <= w_led;

      if (w_tick) begin
        if (w_mode_in != r_mode) begin
          // New mode starts from its first state on this very tick.
          r_mode      <= w_mode_in;
          r_step      <= '0;
          r_pos       <= '0;
          r_pos_down  <= 1'b0;
          r_duty      <= '0;
          r_duty_down <= 1'b0;
        end else begin
          r_step <= r_step + N_LEDS'(1);

          // Direction flips on the same tick that leaves an end position,
          // so each end is shown for exactly one tick.
          if (N_LEDS > 1) begin
            if (!r_pos_down) begin
              if (r_pos == POS_MAX) begin
                r_pos      <= r_pos - PW'(1);
                r_pos_down <= 1'b1;
              end else begin
                r_pos <= r_pos + PW'(1);
              end
            end else begin
              if (r_pos == '0) begin
                r_pos      <= r_pos + PW'(1);
                r_pos_down <= 1'b0;
              end else begin
                r_pos <= r_pos - PW'(1);
              end
            end
          end

          if (!r_duty_down) begin
            if (r_duty == DUTY_MAX) begin
              r_duty      <= r_duty - PWM_BITS'(1);
              r_duty_down <= 1'b1;
            end else begin
              r_duty <= r_duty + PWM_BITS'(1);
            end
          end else begin
            if (r_duty == '0) begin
              r_duty      <= r_duty + PWM_BITS'(1);
              r_duty_down <= 1'b0;
            end else begin
              r_duty <= r_duty - PWM_BITS'(1);
            end
          end
        end
      end
    end
  end

  assign LED  = r_led;
  assign TICK = w_tick;

endmodule
